ensemble_vote_ctrl: RTL
=======================

// Module: ensemble_vote_ctrl
// PURPOSE
//  Sequencer and voter for the three-classifier ensemble (gaussian_nb, gradient_boost, mlp).
//  - Accepts one feature vector on a single AXI-Stream input and broadcasts it to all three
//    classifier inputs, with per-lane fork handshaking.
//  - Collects one result per classifier, majority-votes the class label and emits one result word.
//  - A timeout guards against a hung classifier.
// PARAMETERS
//  DATA_WIDTH   32     stream data width (all streams)
//  KEEP_WIDTH   4      tkeep width (DATA_WIDTH/8)
//  CLASS_WIDTH  8      label = result_tdata[CLASS_WIDTH-1:0]; must be <= DATA_WIDTH-5
//  TIMEOUT      65535  max cycles in COLLECT before forced vote; must be >= 1
// PORTS
//  clk            in   1             clock, all logic rising-edge
//  rst_n          in   1             asynchronous active-low reset
//  s_axis_tdata   in   DATA_WIDTH    feature beat
//  s_axis_tkeep   in   KEEP_WIDTH    feature byte enables (passed through)
//  s_axis_tvalid  in   1             feature beat valid
//  s_axis_tready  out  1             feature beat accepted
//  s_axis_tlast   in   1             last beat of vector
//  c_axis_tdata   out  DATA_WIDTH    broadcast beat to classifiers (= s_axis_tdata)
//  c_axis_tkeep   out  KEEP_WIDTH    = s_axis_tkeep
//  c_axis_tlast   out  1             = s_axis_tlast
//  c_axis_tvalid  out  3             per-classifier valid; bit k = classifier k
//  c_axis_tready  in   3             per-classifier ready
//  r_axis_tdata   in   3*DATA_WIDTH  classifier results; lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//  r_axis_tvalid  in   3             result valid per classifier
//  r_axis_tready  out  3             result ready per classifier
//  r_axis_tlast   in   3             result last beat per classifier
//  m_axis_tdata   out  DATA_WIDTH    vote word
//  m_axis_tkeep   out  KEEP_WIDTH    all ones while m_axis_tvalid=1
//  m_axis_tvalid  out  1             vote word valid
//  m_axis_tready  in   1             downstream ready
//  m_axis_tlast   out  1             1 with every vote word
//  busy           out  1             1 in any state other than IDLE
// BEHAVIOUR
//  Reset
//  - All outputs 0; state=IDLE; done/got/timeout counter cleared.
//  - Reset mid-vector abandons the vector with no output word.
//  - After reset, s_axis_tready stays 0 until the cycle after rst_n deasserts.
//  FSM
//  - IDLE -> FEED on s_axis_tvalid.
//  - FEED: stays until the tlast beat is accepted, then -> COLLECT.
//  - COLLECT -> VOTE when got==3'b111 or tcnt==TIMEOUT.
//  - VOTE: 1 cycle, registers the vote word -> OUT.
//  - OUT -> IDLE on m_axis_tready & m_axis_tvalid.
//  Fork (FEED only; all fork outputs 0 in other states)
//  - c_axis_tvalid[k] = s_axis_tvalid & ~done[k].
//  - s_axis_tready = &(done | c_axis_tready).
//  - done[k] sets on a lane-k handshake without s_axis_tready; all done bits clear on an
//    s_axis handshake.
//  - No lane ever receives a beat twice; no beat is lost.
//  Collect (FEED and COLLECT)
//  - r_axis_tready[k] = ~got[k].
//  - First accepted beat of lane k latches lab[k].
//  - Further beats are discarded.
//  - got[k] sets on the accepted beat with tlast.
//  - A result may complete during FEED.
//  - tcnt clears on COLLECT entry and increments each COLLECT cycle.
//  Vote (g = got mask at VOTE)
//  - Candidates are lanes with g set.
//  - If two or more candidate labels match, the output is that label.
//  - If candidates disagree, the output is the label of the highest-index candidate
//    (mlp priority).
//  - If g==0, the output label is 0.
//  Output word
//  - [CLASS_WIDTH-1:0]=label.
//  - [CLASS_WIDTH+:3]=g.
//  - [CLASS_WIDTH+3]=unanimous (g==7 and all labels equal).
//  - [DATA_WIDTH-1]=timeout (g!=7).
//  - Other bits 0.
//  - Held stable while m_axis_tvalid & ~m_axis_tready.
//  Latency and stalls
//  - Latency: m_axis_tvalid rises 2 cycles after the last got bit sets (COLLECT->VOTE->OUT).
//  - While in COLLECT, VOTE or OUT, s_axis_tready=0 and the next vector stalls.
//  - Late results from a timed-out lane are ignored until the next FEED.
// TESTING
//  - 4-beat vector, all c_axis_tready=1 -> each lane sees 4 beats, tlast on beat 4;
//    labels 2,2,2 -> tdata label 2, g=7, unanimous=1, timeout=0.
//  - Lane ready skew: c_axis_tready=3'b101 for 3 cycles then 3'b111 -> each lane receives
//    each beat exactly once; s_axis_tready low during skew.
//  - Labels 1,3,3 -> 3; labels 1,2,3 -> 3 (tie to mlp); labels 4,4,7 -> 4, unanimous=0.
//  - Lane 1 never responds, TIMEOUT=16, labels 5,_,6 -> VOTE at tcnt=16; label 6, g=3'b101,
//    bit31=1.
//  - m_axis_tready=0 for 10 cycles -> word held stable, busy=1, s_axis_tready=0.
//  - rst_n low during FEED beat 2 -> all outputs 0 immediately; a new vector after reset
//    completes normally.

Source files
------------

// File: rtl/ensemble_vote_ctrl.sv
// Feature broadcaster and majority voter for the three-classifier ensemble.
// One input vector is forked to all classifiers, their labels are collected and voted into one word.
module ensemble_vote_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = 4,
    parameter int CLASS_WIDTH = 8,
    parameter int TIMEOUT     = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [DATA_WIDTH-1:0]   c_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   c_axis_tkeep,
    output logic                    c_axis_tlast,
    output logic [2:0]              c_axis_tvalid,
    input  logic [2:0]              c_axis_tready,
    input  logic [3*DATA_WIDTH-1:0] r_axis_tdata,
    input  logic [2:0]              r_axis_tvalid,
    output logic [2:0]              r_axis_tready,
    input  logic [2:0]              r_axis_tlast,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    busy
);

    localparam int TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FEED    = 3'd1,
        ST_COLLECT = 3'd2,
        ST_VOTE    = 3'd3,
        ST_OUT     = 3'd4
    } state_e;

    state_e                         state_q, state_d;
    logic [2:0]                     done_q, done_d;
    logic [2:0]                     got_q, got_d;
    logic [2:0]                     seen_q, seen_d;
    logic [2:0][CLASS_WIDTH-1:0]    lab_q, lab_d;
    logic [TCW-1:0]                 tcnt_q, tcnt_d;
    logic [DATA_WIDTH-1:0]          m_data_q, m_data_d;
    logic                           m_valid_q, m_valid_d;

    logic                           s_ready_s;
    logic [2:0]                     c_valid_s;
    logic [2:0]                     r_ready_s;
    logic                           s_hs_s;
    logic                           feed_start_s;
    logic                           feed_end_s;
    logic                           timeout_hit_s;
    logic [CLASS_WIDTH-1:0]         vote_label_s;
    logic                           unanimous_s;
    logic [DATA_WIDTH-1:0]          vote_word_s;
    logic                           unused_bits_s;

    // Upper result bits carry nothing the voter needs.
    assign unused_bits_s = ^r_axis_tdata;

    assign s_hs_s        = s_axis_tvalid & s_ready_s;
    assign feed_start_s  = (state_q == ST_IDLE) & s_axis_tvalid;
    assign feed_end_s    = (state_q == ST_FEED) & s_hs_s & s_axis_tlast;
    assign timeout_hit_s = (tcnt_q == TCW'(TIMEOUT));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (s_axis_tvalid) state_d = ST_FEED;
                else               state_d = ST_IDLE;
            end
            ST_FEED: begin
                if (s_hs_s && s_axis_tlast) state_d = ST_COLLECT;
                else                        state_d = ST_FEED;
            end
            ST_COLLECT: begin
                if ((got_q == 3'b111) || timeout_hit_s) state_d = ST_VOTE;
                else                                    state_d = ST_COLLECT;
            end
            ST_VOTE: state_d = ST_OUT;
            ST_OUT: begin
                if (m_valid_q && m_axis_tready) state_d = ST_IDLE;
                else                            state_d = ST_OUT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: fork handshake in FEED, result acceptance in FEED and COLLECT
    always_comb begin
        s_ready_s    = 1'b0;
        c_valid_s    = 3'b000;
        r_ready_s    = 3'b000;
        c_axis_tdata = '0;
        c_axis_tkeep = '0;
        c_axis_tlast = 1'b0;
        busy         = (state_q != ST_IDLE);
        case (state_q)
            ST_FEED: begin
                // A lane that already took the beat no longer holds the fork back.
                c_valid_s    = {3{s_axis_tvalid}} & ~done_q;
                s_ready_s    = &(done_q | c_axis_tready);
                r_ready_s    = ~got_q;
                c_axis_tdata = s_axis_tdata;
                c_axis_tkeep = s_axis_tkeep;
                c_axis_tlast = s_axis_tlast;
            end
            ST_COLLECT: begin
                r_ready_s = ~got_q;
            end
            default: begin
                r_ready_s = 3'b000;
            end
        endcase
    end

    assign s_axis_tready = s_ready_s;
    assign c_axis_tvalid = c_valid_s;
    assign r_axis_tready = r_ready_s;

    // Per-lane fork completion tracking
    always_comb begin
        done_d = done_q;
        if (state_q == ST_FEED) begin
            if (s_hs_s) begin
                done_d = 3'b000;
            end else begin
                done_d = done_q | (c_valid_s & c_axis_tready);
            end
        end else begin
            done_d = 3'b000;
        end
    end

    // Result capture: first beat carries the label, tlast completes the lane
    always_comb begin
        got_d  = got_q;
        seen_d = seen_q;
        lab_d  = lab_q;
        if (feed_start_s) begin
            got_d  = 3'b000;
            seen_d = 3'b000;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (r_ready_s[k] && r_axis_tvalid[k]) begin
                    if (!seen_q[k]) begin
                        lab_d[k]  = r_axis_tdata[k*DATA_WIDTH +: CLASS_WIDTH];
                        seen_d[k] = 1'b1;
                    end else begin
                        lab_d[k] = lab_q[k];
                    end
                    if (r_axis_tlast[k]) begin
                        got_d[k] = 1'b1;
                    end else begin
                        got_d[k] = got_q[k];
                    end
                end else begin
                    got_d[k] = got_q[k];
                end
            end
        end
    end

    // Collect-phase timeout counter
    always_comb begin
        tcnt_d = tcnt_q;
        if (feed_end_s) begin
            tcnt_d = '0;
        end else if ((state_q == ST_COLLECT) && !timeout_hit_s) begin
            tcnt_d = tcnt_q + TCW'(1);
        end else begin
            tcnt_d = tcnt_q;
        end
    end

    // Majority vote with highest-index priority when nothing agrees
    always_comb begin
        vote_label_s = '0;
        if (got_q[0] && got_q[1] && (lab_q[0] == lab_q[1])) begin
            vote_label_s = lab_q[0];
        end else if (got_q[0] && got_q[2] && (lab_q[0] == lab_q[2])) begin
            vote_label_s = lab_q[0];
        end else if (got_q[1] && got_q[2] && (lab_q[1] == lab_q[2])) begin
            vote_label_s = lab_q[1];
        end else if (got_q[2]) begin
            vote_label_s = lab_q[2];
        end else if (got_q[1]) begin
            vote_label_s = lab_q[1];
        end else if (got_q[0]) begin
            vote_label_s = lab_q[0];
        end else begin
            vote_label_s = '0;
        end
    end

    assign unanimous_s = (got_q == 3'b111) && (lab_q[0] == lab_q[1]) && (lab_q[1] == lab_q[2]);

    // Vote word layout: label, got mask, unanimous flag, timeout flag in the MSB
    always_comb begin
        vote_word_s                      = '0;
        vote_word_s[CLASS_WIDTH-1:0]     = vote_label_s;
        vote_word_s[CLASS_WIDTH +: 3]    = got_q;
        vote_word_s[CLASS_WIDTH+3]       = unanimous_s;
        vote_word_s[DATA_WIDTH-1]        = (got_q != 3'b111);
    end

    // Output word register, held until the downstream handshake
    always_comb begin
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        if (state_q == ST_VOTE) begin
            m_data_d  = vote_word_s;
            m_valid_d = 1'b1;
        end else if ((state_q == ST_OUT) && m_valid_q && m_axis_tready) begin
            m_data_d  = '0;
            m_valid_d = 1'b0;
        end else begin
            m_data_d  = m_data_q;
            m_valid_d = m_valid_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q    <= 3'b000;
            got_q     <= 3'b000;
            seen_q    <= 3'b000;
            lab_q     <= '0;
            tcnt_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            done_q    <= done_d;
            got_q     <= got_d;
            seen_q    <= seen_d;
            lab_q     <= lab_d;
            tcnt_q    <= tcnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tkeep  = {KEEP_WIDTH{m_valid_q}};
    assign m_axis_tlast  = m_valid_q;

endmodule
